modulo_step_counter: RTL and testbench

//  Parametrised successor to the team's N-bit up/down counter: counts over a runtime

---
 rtl/modulo_step_counter.sv | 122 ++++++++++++
 tb/tb_modulo_step_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/modulo_step_counter.sv
// Modulo/step up-down counter with wrap or saturate mode, clamped load and registered tc pulse.
// Optional compare output enabled by defining MODULO_STEP_COUNTER_MATCH_EN.
module modulo_step_counter #(
  parameter int N = 8,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         up_down,
  input  logic         mode,
  input  logic         load,
  input  logic [N-1:0] data_in,
  input  logic [N-1:0] mod_max,
  input  logic [S-1:0] step,
`ifdef MODULO_STEP_COUNTER_MATCH_EN
  input  logic [N-1:0] cmp_val,
  output logic         match,
`endif
  output logic [N-1:0] counter,
  output logic         tc,
  output logic         at_max,
  output logic         at_zero
);

  localparam int W = ((N > S) ? N : S) + 1;

  // min(step, mod_max); the result never exceeds mod_max so N+1 bits always suffice
  function automatic logic [N:0] eff_step(input logic [S-1:0] s, input logic [N-1:0] m);
    logic [W-1:0] sw;
    logic [W-1:0] mw;
    sw = W'(s);
    mw = W'(m);
    return (sw < mw) ? (N+1)'(sw) : (N+1)'(mw);
  endfunction

  function automatic logic [N:0] umin(input logic [N:0] a, input logic [N:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [N-1:0] counter_q, counter_d;
  logic         tc_q, tc_d;
  logic [N:0]   cnt, mx, st, sum;

  always_comb begin
    cnt       = {1'b0, counter_q};
    mx        = {1'b0, mod_max};
    st        = eff_step(step, mod_max);
    sum       = cnt + st;
    counter_d = counter_q;
    tc_d      = 1'b0;
    if (load) begin
      counter_d = N'(umin({1'b0, data_in}, mx));
    end else if (enable) begin
      if (mod_max == '0) begin
        counter_d = '0;
        tc_d      = 1'b1;
      end else if (cnt > mx) begin
        // mod_max was lowered below the current count
        counter_d = up_down ? '0 : mod_max;
        tc_d      = 1'b1;
      end else if (st != '0) begin
        if (up_down) begin
          if (mode) begin
            counter_d = N'(umin(sum, mx));
            tc_d      = (sum >= mx);
          end else if (sum <= mx) begin
            counter_d = N'(sum);
          end else begin
            counter_d = N'(sum - mx - 1'b1);
            tc_d      = 1'b1;
          end
        end else begin
          if (mode) begin
            if (cnt <= st) begin
              counter_d = '0;
              tc_d      = 1'b1;
            end else begin
              counter_d = N'(cnt - st);
            end
          end else if (cnt >= st) begin
            counter_d = N'(cnt - st);
          end else begin
            counter_d = N'(cnt + mx + 1'b1 - st);
            tc_d      = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
      tc_q      <= 1'b0;
    end else begin
      counter_q <= counter_d;
      tc_q      <= tc_d;
    end
  end

  assign counter = counter_q;
  assign tc      = tc_q;
  assign at_max  = (counter_q == mod_max);
  assign at_zero = (counter_q == '0);

`ifdef MODULO_STEP_COUNTER_MATCH_EN
  logic match_q, match_d;

  always_comb begin
    match_d = (counter_d == cmp_val);
  end

  always_ff @(posedge clk) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match_d;
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_modulo_step_counter.sv
// Directed table-driven bench for modulo_step_counter, plus hand sequences for
// combinational status flags and (when MODULO_STEP_COUNTER_MATCH_EN is defined) the match output.
module tb_modulo_step_counter;
  localparam int N = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset, enable, up_down, mode, load;
  logic [N-1:0] data_in, mod_max;
  logic [S-1:0] step;
  logic [N-1:0] counter;
  logic         tc, at_max, at_zero;
`ifdef MODULO_STEP_COUNTER_MATCH_EN
  logic [N-1:0] cmp_val;
  logic         match;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  modulo_step_counter #(.N(N), .S(S)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .up_down (up_down),
    .mode    (mode),
    .load    (load),
    .data_in (data_in),
    .mod_max (mod_max),
    .step    (step),
`ifdef MODULO_STEP_COUNTER_MATCH_EN
    .cmp_val (cmp_val),
    .match   (match),
`endif
    .counter (counter),
    .tc      (tc),
    .at_max  (at_max),
    .at_zero (at_zero)
  );

  typedef struct {
    logic         rst, en, ud, md, ld;
    logic [N-1:0] din, mm;
    logic [S-1:0] st;
    logic [N-1:0] e_cnt;
    logic         e_tc, e_max, e_zero;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, en, ud, md, ld, input int din, mm, st,
                     input int e_cnt, input logic e_tc, e_max, e_zero);
    vec_t v;
    v.rst = rst; v.en = en; v.ud = ud; v.md = md; v.ld = ld;
    v.din = N'(din); v.mm = N'(mm); v.st = S'(st);
    v.e_cnt = N'(e_cnt); v.e_tc = e_tc; v.e_max = e_max; v.e_zero = e_zero;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; up_down = 1'b1; mode = 1'b0; load = 1'b0;
    data_in = '0; mod_max = 8'd9; step = 4'd3;
`ifdef MODULO_STEP_COUNTER_MATCH_EN
    cmp_val = 8'd6;
`endif

    //   rst en ud md ld din  mm  st   cnt tc max zero
    add(1, 1, 1, 0, 0,   0,   9,  3,    0, 0, 0, 1);
    add(1, 1, 1, 0, 0,   0,   9,  3,    0, 0, 0, 1);
    add(0, 1, 1, 0, 0,   0,   9,  3,    3, 0, 0, 0);
    add(0, 1, 1, 0, 0,   0,   9,  3,    6, 0, 0, 0);
    add(0, 1, 1, 0, 0,   0,   9,  3,    9, 0, 1, 0);
    add(0, 1, 1, 0, 0,   0,   9,  3,    2, 1, 0, 0);
    add(0, 1, 1, 0, 0,   0,   9,  3,    5, 0, 0, 0);
    add(0, 1, 1, 0, 0,   0,   9,  3,    8, 0, 0, 0);
    add(0, 1, 1, 0, 0,   0,   9,  3,    1, 1, 0, 0);
    add(0, 1, 0, 0, 1,   2,   9,  3,    2, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0,   9,  4,    8, 1, 0, 0);
    add(0, 1, 0, 0, 0,   0,   9,  4,    4, 0, 0, 0);
    add(0, 1, 1, 1, 1, 190, 200, 15,  190, 0, 0, 0);
    add(0, 1, 1, 1, 0,   0, 200, 15,  200, 1, 1, 0);
    add(0, 1, 1, 1, 0,   0, 200, 15,  200, 1, 1, 0);
    add(0, 1, 0, 1, 0,   0, 200, 15,  185, 0, 0, 0);
    add(0, 1, 1, 0, 1, 250, 100, 15,  100, 0, 1, 0);
    add(0, 1, 1, 0, 0,   0,  50, 15,    0, 1, 0, 1);
    add(0, 0, 1, 0, 0,   0,  50, 15,    0, 0, 0, 1);
    add(0, 1, 1, 0, 0,   0,   9,  0,    0, 0, 0, 1);
    add(0, 1, 1, 0, 0,   0,   0,  3,    0, 1, 1, 1);
    add(0, 1, 0, 0, 0,   0,   0,  3,    0, 1, 1, 1);
    add(0, 1, 1, 0, 0,   0,   2, 15,    2, 0, 1, 0);
    add(0, 1, 1, 0, 0,   0,   2, 15,    1, 1, 0, 0);
    add(0, 1, 0, 1, 0,   0,   9,  3,    0, 1, 0, 1);
    add(0, 1, 0, 1, 0,   0,   9,  3,    0, 1, 0, 1);
    add(0, 1, 1, 0, 0,   0,   9,  3,    3, 0, 0, 0);
    add(1, 1, 1, 0, 0,   0,   9,  3,    0, 0, 0, 1);
    add(0, 1, 1, 0, 1, 250, 255, 15,  250, 0, 0, 0);
    add(0, 1, 1, 0, 0,   0, 255, 15,    9, 1, 0, 0);
    add(0, 1, 0, 0, 0,   0, 255, 15,  250, 1, 0, 0);
    add(0, 1, 1, 1, 0,   0, 255, 15,  255, 1, 1, 0);
    add(0, 1, 0, 0, 0,   0, 100, 15,  100, 1, 1, 0);
    add(1, 1, 1, 0, 1,  50, 100, 15,    0, 0, 0, 1);
    add(0, 1, 1, 0, 1,  70, 100, 15,   70, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; enable = vecs[i].en; up_down = vecs[i].ud; mode = vecs[i].md;
      load = vecs[i].ld; data_in = vecs[i].din; mod_max = vecs[i].mm; step = vecs[i].st;
      @(posedge clk);
      #1;
      check($sformatf("v%0d counter", i), 32'(counter), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d tc", i),      32'(tc),      32'(vecs[i].e_tc));
      check($sformatf("v%0d at_max", i),  32'(at_max),  32'(vecs[i].e_max));
      check($sformatf("v%0d at_zero", i), 32'(at_zero), 32'(vecs[i].e_zero));
    end

    // at_max follows mod_max combinationally with the counter held at 70
    @(negedge clk);
    load = 1'b0; enable = 1'b0; mod_max = 8'd70;
    #1;
    check("comb at_max hit", 32'(at_max), 32'd1);
    mod_max = 8'd71;
    #1;
    check("comb at_max miss", 32'(at_max), 32'd0);
    check("hold counter", 32'(counter), 32'd70);

`ifdef MODULO_STEP_COUNTER_MATCH_EN
    @(negedge clk);
    reset = 1'b1; enable = 1'b1; up_down = 1'b1; mode = 1'b0; mod_max = 8'd9; step = 4'd3;
    cmp_val = 8'd6;
    @(posedge clk); #1;
    check("match after reset", 32'(match), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("match at 3", 32'(match), 32'd0);
    @(posedge clk); #1;
    check("counter 6", 32'(counter), 32'd6);
    check("match at 6", 32'(match), 32'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("reset counter", 32'(counter), 32'd0);
    check("reset match", 32'(match), 32'd0);
    reset = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected finish before 100000");
    $fatal(1);
  end

endmodule
